// File: rtl/handshake_tx_queue_pkg.sv
// Shared definitions for the handshake transmit queue: FSM encoding and sizing helpers.
package handshake_tx_queue_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_WAIT_REQ = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_WAIT_CLR = 3'd4;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/handshake_tx_queue_sync_fifo.sv
// Single-clock FIFO; full/empty come from the occupancy counter's extra bit.
module sync_fifo
  import handshake_tx_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  localparam int ADDR_W    = addr_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_W:0]       o_level
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = r_count[ADDR_W];
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_tx_queue.sv
// Source-side queue feeding the mux-handshake synchronizer one word per req/ack round trip.
// Optional handshake watchdog and o_timeout port under HSQ_TIMEOUT_EN.
module handshake_tx_queue
  import handshake_tx_queue_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ADDR_W        = addr_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_hs_wr,
  output logic [DATA_WIDTH-1:0] o_hs_data,
  input  logic                  i_hs_rdy,
  input  logic                  i_hs_ack,
  output logic                  o_busy,
  output logic [ADDR_W:0]       o_level
`ifdef HSQ_TIMEOUT_EN
  ,
  output logic                  o_timeout
`endif
);

  // state    | meaning
  // IDLE     | waiting for a queued word, rdy high and ack low
  // WRITE    | strobe cycle, word presented to synchronizer
  // WAIT_REQ | waiting for the request to latch (rdy low)
  // WAIT_ACK | waiting for the destination ack; pop on arrival
  // WAIT_CLR | waiting for ack release before the next strobe
  logic [2:0]            r_state;
  logic                  r_hs_wr;
  logic [DATA_WIDTH-1:0] r_hs_data;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_start;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   (i_s_data),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (o_level)
  );

  assign o_s_ready = ~w_full;
  assign w_push    = i_s_valid & ~w_full;
  assign w_pop     = (r_state == ST_WAIT_ACK) & i_hs_ack;
  // A strobe while ack is still high would be masked by the synchronizer.
  assign w_start   = (r_state == ST_IDLE) & ~w_empty & i_hs_rdy & ~i_hs_ack;
  assign o_hs_wr   = r_hs_wr;
  assign o_hs_data = r_hs_data;
  assign o_busy    = (r_state != ST_IDLE) | ~w_empty;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state   <= ST_IDLE;
      r_hs_wr   <= 1'b0;
      r_hs_data <= '0;
    end else begin
      r_hs_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_hs_data <= w_head;
            r_hs_wr   <= 1'b1;
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE:    r_state <= ST_WAIT_REQ;
        ST_WAIT_REQ: if (!i_hs_rdy && !i_hs_ack) r_state <= ST_WAIT_ACK;
        ST_WAIT_ACK: if (i_hs_ack) r_state <= ST_WAIT_CLR;
        ST_WAIT_CLR: if (!i_hs_ack) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HSQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_next;
  logic            w_waiting;
  logic            r_timeout;

  assign w_waiting = (r_state == ST_WAIT_REQ) | (r_state == ST_WAIT_ACK) |
                     (r_state == ST_WAIT_CLR);
  assign o_timeout = r_timeout;

  always_comb begin
    w_wd_next = '0;
    if (w_waiting) w_wd_next = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + WD_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_next;
      if (w_wd_next == WD_MAX) r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule
